// File: rtl/cc_collision_scanner_pkg.sv
// rtl/cc_collision_scanner_pkg.sv - shared scan FSM state type and row-index width helper
package cc_collision_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } scan_state_e;

  // Never narrower than one bit so a 2-row scanner still has a usable index.
  function automatic int unsigned row_idx_width(input int unsigned rows);
    return (rows <= 2) ? 1 : $clog2(rows);
  endfunction

endpackage

// File: rtl/cc_collision_scanner_rowcmp.sv
// rtl/cc_collision_scanner_rowcmp.sv - one-row overlap test between road data and player mask
module cc_collision_scanner_rowcmp #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] row_data,
  input  logic [DW-1:0] play_mask,
  output logic          hit
);

  assign hit = |(row_data & play_mask);

endmodule

// File: rtl/cc_collision_scanner.sv
// rtl/cc_collision_scanner.sv - scans road rows against the latched player row and reports the first hit
// Optional: CC_COLLISION_SCANNER_EARLYEXIT_EN ends the pass at the first hit row.
module cc_collision_scanner
  import cc_collision_scanner_pkg::*;
#(
  parameter int COLLISION_SCANNER_DATAWIDTH = 8,
  parameter int COLLISION_SCANNER_ROWS      = 8
) (
  input  logic                                                 CC_COLLISION_SCANNER_CLOCK_50,
  input  logic                                                 CC_COLLISION_SCANNER_RESET_InHigh,
  input  logic                                                 CC_COLLISION_SCANNER_start_InHigh,
  input  logic [COLLISION_SCANNER_DATAWIDTH-1:0]               CC_COLLISION_SCANNER_play_InBUS,
  input  logic [COLLISION_SCANNER_DATAWIDTH-1:0]               CC_COLLISION_SCANNER_rowdata_InBUS,
  output logic [row_idx_width(COLLISION_SCANNER_ROWS)-1:0]     CC_COLLISION_SCANNER_rowsel_OutBUS,
  output logic                                                 CC_COLLISION_SCANNER_busy_OutHigh,
  output logic                                                 CC_COLLISION_SCANNER_done_OutHigh,
  output logic                                                 CC_COLLISION_SCANNER_crash_OutHigh,
  output logic [row_idx_width(COLLISION_SCANNER_ROWS)-1:0]     CC_COLLISION_SCANNER_hitrow_OutBUS
);

  localparam int DW = COLLISION_SCANNER_DATAWIDTH;
  localparam int RW = row_idx_width(COLLISION_SCANNER_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(COLLISION_SCANNER_ROWS - 1);

`ifdef CC_COLLISION_SCANNER_EARLYEXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  scan_state_e   state_q, state_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic [DW-1:0] play_q, play_d;
  logic          crash_q, crash_d;
  logic [RW-1:0] hitrow_q, hitrow_d;
  logic          hit;

  cc_collision_scanner_rowcmp #(
    .DW (DW)
  ) u_rowcmp (
    .row_data  (CC_COLLISION_SCANNER_rowdata_InBUS),
    .play_mask (play_q),
    .hit       (hit)
  );

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    play_d    = play_q;
    crash_d   = crash_q;
    hitrow_d  = hitrow_q;
    case (state_q)
      ST_IDLE: begin
        if (CC_COLLISION_SCANNER_start_InHigh) begin
          play_d    = CC_COLLISION_SCANNER_play_InBUS;
          row_idx_d = '0;
          crash_d   = 1'b0;
          hitrow_d  = '0;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        // Only the first hit of a pass records its row.
        if (hit && !crash_q) begin
          crash_d  = 1'b1;
          hitrow_d = row_idx_q;
        end
        if ((row_idx_q == LAST_ROW) || (EARLY_EXIT && hit)) begin
          state_d = ST_DONE;
        end else begin
          row_idx_d = row_idx_q + RW'(1);
          state_d   = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CC_COLLISION_SCANNER_CLOCK_50) begin
    if (CC_COLLISION_SCANNER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      row_idx_q <= '0;
      play_q    <= '0;
      crash_q   <= 1'b0;
      hitrow_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      play_q    <= play_d;
      crash_q   <= crash_d;
      hitrow_q  <= hitrow_d;
    end
  end

  assign CC_COLLISION_SCANNER_rowsel_OutBUS = row_idx_q;
  assign CC_COLLISION_SCANNER_busy_OutHigh  = (state_q == ST_SELECT) || (state_q == ST_COMPARE);
  assign CC_COLLISION_SCANNER_done_OutHigh  = (state_q == ST_DONE);
  assign CC_COLLISION_SCANNER_crash_OutHigh = crash_q;
  assign CC_COLLISION_SCANNER_hitrow_OutBUS = hitrow_q;

endmodule

// File: doc/cc_collision_scanner.md
CC_COLLISION_SCANNER -- requirements
Module: cc_collision_scanner

Interface
REQ-001 SHALL have parameter COLLISION_SCANNER_DATAWIDTH, default 8: width of one road row and of the player row.
REQ-002 SHALL have parameter COLLISION_SCANNER_ROWS, default 8: number of rows scanned per pass, range 2..16.
REQ-003 SHALL have port CC_COLLISION_SCANNER_CLOCK_50  in  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port CC_COLLISION_SCANNER_RESET_InHigh  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port CC_COLLISION_SCANNER_start_InHigh  in  1: one-cycle request to start a scan pass.
REQ-006 SHALL have port CC_COLLISION_SCANNER_play_InBUS  in  DATAWIDTH: player car row mask.
REQ-007 SHALL have port CC_COLLISION_SCANNER_rowdata_InBUS  in  DATAWIDTH: road row data, valid one cycle after row_sel is presented.
REQ-008 SHALL have port CC_COLLISION_SCANNER_rowsel_OutBUS  out  clog2(ROWS): row index presented to the road register bank.
REQ-009 SHALL have port CC_COLLISION_SCANNER_busy_OutHigh  out  1: high while a pass is in progress.
REQ-010 SHALL have port CC_COLLISION_SCANNER_done_OutHigh  out  1: one-cycle pulse at the end of a pass.
REQ-011 SHALL have port CC_COLLISION_SCANNER_crash_OutHigh  out  1: result of the last pass, high when at least one row hit.
REQ-012 SHALL have port CC_COLLISION_SCANNER_hitrow_OutBUS  out  clog2(ROWS): lowest hit row index of the last pass.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, COMPARE and DONE.
REQ-014 SHALL, in IDLE with start high, latch play_InBUS, clear the row index, crash and hitrow, and move to SELECT; play changes during a pass SHALL be ignored.
REQ-015 SHALL ignore start in all states except IDLE (no queuing).
REQ-016 SHALL, in SELECT, drive rowsel = row index and move to COMPARE on the next cycle.
REQ-017 SHALL, in COMPARE, evaluate hit = OR-reduce(rowdata AND latched play).
REQ-018 SHALL, on the first hit of a pass, set crash and store the row index in hitrow; later hits SHALL NOT overwrite hitrow.
REQ-019 SHALL, in COMPARE, move to DONE when the row index = ROWS-1 (or on an early exit per REQ-026); otherwise increment the index and return to SELECT.
REQ-020 SHALL hold busy high in SELECT and COMPARE, and done high only in DONE; DONE SHALL return to IDLE after one cycle.
REQ-021 SHALL make the latency from the start edge to done 2*ROWS+1 cycles for a full pass; the row index SHALL never exceed ROWS-1.
REQ-022 SHALL hold crash and hitrow stable from DONE until the next accepted start.

Reset
REQ-023 SHALL, when reset is high at a clock edge, including mid-pass, force IDLE, and set rowsel=0, busy=0, done=0, crash=0, hitrow=0 and the latched play to 0.
REQ-024 SHALL NOT produce a done pulse for a pass aborted by reset.

Configuration
REQ-025 SHALL use macro CC_COLLISION_SCANNER_EARLYEXIT_EN to select the early-exit behaviour.
REQ-026 SHALL, with CC_COLLISION_SCANNER_EARLYEXIT_EN defined, go from COMPARE directly to DONE on the first hit, giving latency 2*(hitrow+1)+1.
REQ-027 SHALL, without CC_COLLISION_SCANNER_EARLYEXIT_EN, always scan all ROWS rows, with latency per REQ-021.

Structure
REQ-028 SHALL place the state enum typedef and the row-index width function/constant in the shared package cc_collision_scanner_pkg.
REQ-029 SHALL implement the row compare (AND/OR-reduce) in the sub-module cc_collision_scanner_rowcmp; the FSM and registers SHALL stay in the top module.

Verification
REQ-030 SHALL cover a no-hit pass: ROWS=8, play=8'h18, all rows 8'h00, start at cycle 0 -> rowsel steps 0..7, done at cycle 17, crash=0, hitrow=0.
REQ-031 SHALL cover a single hit: row2=8'h10 and the rest 8'h00 -> crash=1, hitrow=2; done at cycle 7 with EARLYEXIT_EN, at cycle 17 without.
REQ-032 SHALL cover multiple hits: row3=8'h08 and row6=8'hFF, macro undefined -> crash=1, hitrow=3, done at cycle 17.
REQ-033 SHALL cover start and play changes while busy: start pulsed at cycle 5, play changed to 8'hFF at cycle 4 -> no effect, a single done pulse, result based on 8'h18.
REQ-034 SHALL cover reset mid-pass: reset high at cycle 6 -> next cycle busy=0, crash=0, rowsel=0, no done pulse; a new start runs a full correct pass.
